sr_flag_bank: RTL
=================

# sr_flag_bank

Parametrised bank of N independent synchronous set/reset status flags, with per-channel priority, optional rising-edge set detection, write-1-to-clear, overrun capture, a saturating overrun counter and a masked, registered interrupt output. It sits between the UART TX/RX datapath and the TSI register interface. It generates the TXRDY/RXRDY-style status bits and the interrupt request the host reads.

## Interface
- N_CH, 8, number of flag channels (1..32)
- RESET_VAL, {N_CH{1'b1}}, per-channel value of q after reset
- SET_DOM, {N_CH{1'b1}}, per channel: 1 = set wins over reset, 0 = reset wins
- EDGE_SET, {N_CH{1'b0}}, per channel: 1 = set acts on rising edge only, 0 = level
- OVF_W, 4, width of the overrun counter
---
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high
- set  input  N_CH  per-channel set request
- rst  input  N_CH  per-channel reset request from hardware
- clr  input  N_CH  write-1-to-clear strobe from the register bus (one cycle)
- int_en  input  N_CH  interrupt enable mask
- q  output  N_CH  flag state
- ovf  output  N_CH  sticky overrun per channel
- ovf_cnt  output  OVF_W  saturating count of cycles with at least one new overrun
- irq  output  1  registered OR of q & int_en

## Operation
- Effective set: set_e[i] = EDGE_SET[i] ? (set[i] & ~set_d[i]) : set[i]. set_d is a registered copy of set.
- Effective reset: rst_e[i] = rst[i] | clr[i].
- Per-channel next q, evaluated in this priority order:
  - set_e & rst_e: the result is SET_DOM[i].
  - Only set_e: the result is 1.
  - Only rst_e: the result is 0.
  - Neither: q holds.
- Overrun: ovf[i] sets when set_e[i] occurs, q[i]==1, and the next q[i] is 1 (no winning reset). ovf[i] clears on clr[i]. If a new overrun and clr[i] occur in the same cycle, the new overrun wins and ovf stays 1.
- Overrun counter:
  - ovf_cnt increments by 1 in any cycle where at least one new overrun occurs.
  - It saturates at 2^OVF_W-1.
  - It clears only on reset.
- irq <= |(next_q & int_en), registered.
- Reset values:
  - q = RESET_VAL
  - ovf = 0
  - ovf_cnt = 0
  - set_d = 0
  - irq = |(RESET_VAL & int_en) from the first clock after reset deassertion; irq is 0 while reset is asserted.
- Reset mid-operation: all state returns to reset values immediately (asynchronously). A set pulse held across reset deassertion counts as an edge in EDGE_SET mode, because set_d = 0.

## Timing
- q, ovf and ovf_cnt update on the clk edge at which the inputs are sampled: 1-cycle latency, no combinational path from inputs to outputs.
- irq is computed from next_q, so it asserts on the same edge that q rises. Changes to int_en affect irq on the next edge.
- clr is a single-cycle strobe. If held for k cycles, it acts k times (idempotent).
- In edge mode, a level held high produces exactly one set_e. A new edge needs set to be low for at least 1 cycle.
- Every channel is fully independent. Simultaneous events on different channels are legal and do not interact, except in the shared ovf_cnt increment.

## Structure
- Sub-module sr_flag_cell: one channel holding q, ovf and set_d, with priority/edge logic configured by scalar parameters SET_DOM, EDGE_SET and RESET_VAL. The top level generates N_CH instances and adds the counter and irq.
- Shared package/header: constants SR_SET_DOM=1 and SR_RST_DOM=0, plus a default OVF_W. These are shared with the TSI register map, which decodes clr from bit positions.

## Test plan
- Reset with N_CH=8, RESET_VAL=8'hFF, int_en=8'h01 -> q=8'hFF, ovf=0, ovf_cnt=0; irq=1 one clock after deassert.
- Channel 0, SET_DOM=1: set=1 and rst=1 in the same cycle -> q[0]=1. Channel 1, SET_DOM=0, same stimulus -> q[1]=0.
- Channel 2, EDGE_SET=1: set held high for 5 cycles after q cleared -> q[2]=1 once, no ovf. Then set low for 1 cycle and high again with q=1 -> ovf[2]=1, ovf_cnt=1.
- Channel 3 level mode, q=1: set held for 20 cycles with OVF_W=4 -> ovf_cnt saturates at 15; clr[3] -> q[3]=0, ovf[3]=0, ovf_cnt stays 15.
- Overrun and clr[4] in the same cycle -> ovf[4] stays 1; q[4] follows SET_DOM[4].
- int_en=8'h10, q[4] rises -> irq rises on the same edge. Then int_en=0 -> irq=0 the next cycle. Assert reset mid-sequence -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sr_flag_bank_pkg.sv
// Shared constants and types for the set/reset flag bank; the register map
// decodes clr bit positions against the same definitions.
package sr_flag_bank_pkg;

  localparam bit          SR_SET_DOM        = 1'b1;
  localparam bit          SR_RST_DOM        = 1'b0;
  localparam int unsigned SR_OVF_W_DEFAULT  = 4;

  // {set_e, rst_e} packed so the cell can decode the request pair in one case
  typedef enum logic [1:0] {
    EvNone = 2'b00,
    EvRst  = 2'b01,
    EvSet  = 2'b10,
    EvBoth = 2'b11
  } sr_event_e;

  function automatic sr_event_e sr_event(input logic set_e, input logic rst_e);
    return sr_event_e'({set_e, rst_e});
  endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// One status-flag channel: flag, sticky overrun and the set history used for
// rising-edge detection.
module sr_flag_cell
  import sr_flag_bank_pkg::*;
#(
  parameter bit SET_DOM   = SR_SET_DOM,
  parameter bit EDGE_SET  = 1'b0,
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_set,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_q,
  output logic o_ovf,
  output logic o_next_q,
  output logic o_new_ovf
);

  logic      r_q;
  logic      r_ovf;
  logic      r_set_d;
  logic      w_set_e;
  logic      w_rst_e;
  logic      w_next_q;
  logic      w_new_ovf;
  logic      w_next_ovf;
  sr_event_e w_ev;

  always_comb begin
    w_set_e  = EDGE_SET ? (i_set & ~r_set_d) : i_set;
    w_rst_e  = i_rst | i_clr;
    w_ev     = sr_event(w_set_e, w_rst_e);
    w_next_q = r_q;
    unique case (w_ev)
      EvBoth:  w_next_q = SET_DOM;
      EvSet:   w_next_q = 1'b1;
      EvRst:   w_next_q = 1'b0;
      default: w_next_q = r_q;
    endcase
    // A set landing on an already-set flag that survives the cycle is lost data
    w_new_ovf  = w_set_e & r_q & w_next_q;
    w_next_ovf = w_new_ovf | (r_ovf & ~i_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q     <= RESET_VAL;
      r_ovf   <= 1'b0;
      r_set_d <= 1'b0;
    end else begin
      r_q     <= w_next_q;
      r_ovf   <= w_next_ovf;
      r_set_d <= i_set;
    end
  end

  assign o_q       = r_q;
  assign o_ovf     = r_ovf;
  assign o_next_q  = w_next_q;
  assign o_new_ovf = w_new_ovf;

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of independent set/reset status flags with overrun tracking, a shared
// saturating overrun counter and a registered, masked interrupt request.
module sr_flag_bank
  import sr_flag_bank_pkg::*;
#(
  parameter int unsigned     N_CH      = 8,
  parameter logic [N_CH-1:0] RESET_VAL = {N_CH{1'b1}},
  parameter logic [N_CH-1:0] SET_DOM   = {N_CH{1'b1}},
  parameter logic [N_CH-1:0] EDGE_SET  = {N_CH{1'b0}},
  parameter int unsigned     OVF_W     = SR_OVF_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  set,
  input  logic [N_CH-1:0]  rst,
  input  logic [N_CH-1:0]  clr,
  input  logic [N_CH-1:0]  int_en,
  output logic [N_CH-1:0]  q,
  output logic [N_CH-1:0]  ovf,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic             irq
);

  logic [N_CH-1:0]  w_next_q;
  logic [N_CH-1:0]  w_new_ovf;
  logic [OVF_W-1:0] r_ovf_cnt;
  logic [OVF_W-1:0] w_ovf_cnt_next;
  logic             r_irq;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sr_flag_cell #(
      .SET_DOM   (SET_DOM[g]),
      .EDGE_SET  (EDGE_SET[g]),
      .RESET_VAL (RESET_VAL[g])
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .i_set     (set[g]),
      .i_rst     (rst[g]),
      .i_clr     (clr[g]),
      .o_q       (q[g]),
      .o_ovf     (ovf[g]),
      .o_next_q  (w_next_q[g]),
      .o_new_ovf (w_new_ovf[g])
    );
  end

  always_comb begin
    w_ovf_cnt_next = r_ovf_cnt;
    if (|w_new_ovf && !(&r_ovf_cnt)) begin
      w_ovf_cnt_next = r_ovf_cnt + {{(OVF_W-1){1'b0}}, 1'b1};
    end
  end

  // irq tracks next_q so it rises on the same edge as the flag itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_cnt <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_ovf_cnt <= w_ovf_cnt_next;
      r_irq     <= |(w_next_q & int_en);
    end
  end

  assign ovf_cnt = r_ovf_cnt;
  assign irq     = r_irq;

endmodule
